// File: rtl/shiftreg_arbiter.sv
// Round-robin arbiter sharing one 74hc595 shift-register driver between N byte producers.
// Optional handshake timeout enabled by defining ARB_TIMEOUT_EN.
module shiftreg_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1024,
    parameter int IW      = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    input  logic [8*N-1:0] i_data,
    output logic [N-1:0]   o_ack,
    output logic [N-1:0]   o_grant,
    output logic [7:0]     o_Data,
    output logic           o_Enable,
    input  logic           i_Ready,
    output logic           o_busy,
    output logic           o_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_gidx;
    logic [N-1:0]  r_grant;
    logic [7:0]    r_data;

    logic [IW-1:0] w_win;
    logic [IW-1:0] w_cand;
    logic          w_found;
    logic          w_go;
    logic          w_abort;
    logic          w_expired;
    int unsigned   w_idx;

    // Search starts one past the last served requester; wrap is modulo N so non-power-of-2 N works.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx  = (32'(r_last) + 32'd1 + k) % 32'(N);
            w_cand = IW'(w_idx);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_go = (r_state == IDLE) && i_Ready && w_found;

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Ready && w_found)
                    w_next = ISSUE;
            end
            ISSUE: w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (w_expired)
                    w_abort = 1'b1;
                else if (!i_Ready)
                    w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_Ready)
                    w_next = ACK;
                else if (w_expired)
                    w_abort = 1'b1;
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort)
            w_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_last  <= IW'(N - 1);
            r_gidx  <= '0;
            r_grant <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_grant <= N'(1) << w_win;
                r_data  <= i_data[8*w_win +: 8];
                r_gidx  <= w_win;
            end else if ((r_state == ACK) || w_abort) begin
                // An aborted requester also moves to the back of the queue.
                r_last  <= r_gidx;
                r_grant <= '0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_expired = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ISSUE)
                r_cnt <= '0;
            else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE))
                r_cnt <= r_cnt + 1'b1;
            if (w_abort)
                r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign w_expired = 1'b0;
    assign o_err     = 1'b0;
`endif

    assign o_grant  = r_grant;
    assign o_Data   = r_data;
    assign o_Enable = (r_state == ISSUE);
    assign o_busy   = (r_state != IDLE);
    assign o_ack    = (r_state == ACK) ? r_grant : '0;

endmodule
